// File: rtl/flood_pkg.sv
// Shared types and constants for the flood-it game start/initialisation controller.
package flood_pkg;

  localparam int unsigned COLOR_W      = 4;
  localparam int unsigned MIN_COLORS   = 3;
  localparam int unsigned MAX_COLORS   = 8;
  localparam int unsigned RESET_COLORS = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_INIT,
    S_PLAY,
    S_ERROR
  } state_t;

  // Saturating colour-count adjust; simultaneous up/down cancel out.
  function automatic logic [COLOR_W-1:0] color_step(input logic [COLOR_W-1:0] c,
                                                    input logic up,
                                                    input logic down);
    logic [COLOR_W-1:0] r;
    r = c;
    if (up && !down && (c < COLOR_W'(MAX_COLORS))) begin
      r = c + COLOR_W'(1);
    end else if (down && !up && (c > COLOR_W'(MIN_COLORS))) begin
      r = c - COLOR_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/init_timer.sv
// Per-attempt INIT timer and retry counter; both saturate rather than wrap.
module init_timer #(
  parameter int unsigned INIT_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic timeout,
  output logic exhausted
);

  localparam int unsigned TIMER_W = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
  localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  logic [TIMER_W-1:0] r_timer;
  logic [RETRY_W-1:0] r_retry;

  assign timeout   = (r_timer == TIMER_W'(INIT_TIMEOUT - 1));
  assign exhausted = (r_retry == RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_timer <= '0;
      r_retry <= '0;
    end else if (run) begin
      if (timeout) begin
        r_timer <= '0;
        if (!exhausted) begin
          r_retry <= r_retry + RETRY_W'(1);
        end
      end else begin
        r_timer <= r_timer + TIMER_W'(1);
      end
    end
  end

endmodule

// File: rtl/game_init_ctrl.sv
// Game start controller: colour selection, start handshake, board init with
// timeout/retry, and play/error tracking. All outputs are registered.
module game_init_ctrl
  import flood_pkg::*;
#(
  parameter int unsigned INIT_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_up,
  input  logic               btn_down,
  input  logic               init_done,
  input  logic               game_over,
  output logic [COLOR_W-1:0] final_COLOR_NUM,
  output logic               BEGIN_GAME,
  output logic               INITIALIZE_BOARD,
  output logic               ACK_BEGIN_GAME,
  output logic               INIT_INIT,
  output logic               BOARD_READY,
  output logic               init_error
);

  state_t             r_state;
  state_t             w_next;
  logic [COLOR_W-1:0] w_color;
  logic               w_init_pulse;
  logic               w_timeout;
  logic               w_exhausted;

  // Timer is held clear outside INIT so every INIT entry starts fresh.
  init_timer #(
    .INIT_TIMEOUT(INIT_TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) u_init_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (r_state != S_INIT),
    .run      ((r_state == S_INIT) && !init_done),
    .timeout  (w_timeout),
    .exhausted(w_exhausted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_color      = final_COLOR_NUM;
    w_init_pulse = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (btn_start) begin
          w_next = S_ACK;
        end else begin
          w_color = color_step(final_COLOR_NUM, btn_up, btn_down);
        end
      end
      S_ACK: w_next = S_INIT;
      S_INIT: begin
        if (init_done) begin
          w_next = S_PLAY;
        end else if (w_timeout && w_exhausted) begin
          w_next = S_ERROR;
        end
      end
      S_PLAY: begin
        if (game_over) begin
          w_next = S_IDLE;
        end else if (btn_start) begin
          w_next = S_ACK;
        end
      end
      S_ERROR: begin
        if (btn_start) begin
          w_next = S_ACK;
        end
      end
      default: w_next = S_IDLE;
    endcase
    // Staying in INIT on a timeout is a retry and re-kicks the generator.
    w_init_pulse = (w_next == S_INIT) && ((r_state != S_INIT) || w_timeout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      final_COLOR_NUM  <= COLOR_W'(RESET_COLORS);
      BEGIN_GAME       <= 1'b0;
      INITIALIZE_BOARD <= 1'b0;
      ACK_BEGIN_GAME   <= 1'b0;
      INIT_INIT        <= 1'b0;
      BOARD_READY      <= 1'b0;
      init_error       <= 1'b0;
    end else begin
      final_COLOR_NUM  <= w_color;
      BEGIN_GAME       <= (w_next == S_PLAY);
      INITIALIZE_BOARD <= (w_next == S_INIT);
      ACK_BEGIN_GAME   <= (w_next == S_ACK);
      INIT_INIT        <= w_init_pulse;
      BOARD_READY      <= (w_next == S_PLAY);
      init_error       <= (w_next == S_ERROR);
    end
  end

endmodule

// File: tb/tb_game_init_ctrl.sv
// Scoreboard bench for game_init_ctrl: a behavioural model pushes expected
// outputs per driven cycle; they are popped and compared after the edge.
module tb_game_init_ctrl;

  localparam int TO = 8;
  localparam int MR = 2;

  localparam int M_IDLE  = 0;
  localparam int M_ACK   = 1;
  localparam int M_INIT  = 2;
  localparam int M_PLAY  = 3;
  localparam int M_ERROR = 4;

  typedef struct packed {
    logic [3:0] color;
    logic       begin_g;
    logic       init_b;
    logic       ack;
    logic       init_init;
    logic       ready;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       btn_start;
  logic       btn_up;
  logic       btn_down;
  logic       init_done;
  logic       game_over;
  logic [3:0] final_COLOR_NUM;
  logic       BEGIN_GAME;
  logic       INITIALIZE_BOARD;
  logic       ACK_BEGIN_GAME;
  logic       INIT_INIT;
  logic       BOARD_READY;
  logic       init_error;

  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb_q[$];

  int m_state = M_IDLE;
  int m_color = 6;
  int m_cyc   = 0;
  int m_att   = 0;

  game_init_ctrl #(
    .INIT_TIMEOUT(TO),
    .MAX_RETRY   (MR)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_start       (btn_start),
    .btn_up          (btn_up),
    .btn_down        (btn_down),
    .init_done       (init_done),
    .game_over       (game_over),
    .final_COLOR_NUM (final_COLOR_NUM),
    .BEGIN_GAME      (BEGIN_GAME),
    .INITIALIZE_BOARD(INITIALIZE_BOARD),
    .ACK_BEGIN_GAME  (ACK_BEGIN_GAME),
    .INIT_INIT       (INIT_INIT),
    .BOARD_READY     (BOARD_READY),
    .init_error      (init_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Advance the model one cycle, push its prediction, clock the DUT, compare.
  task automatic step(input logic r, input logic s, input logic u, input logic d,
                      input logic dn, input logic ov);
    exp_t e;
    exp_t got;
    logic pulse;
    rst = r; btn_start = s; btn_up = u; btn_down = d; init_done = dn; game_over = ov;
    pulse = 1'b0;
    if (r) begin
      m_state = M_IDLE; m_color = 6; m_cyc = 0; m_att = 0;
    end else begin
      case (m_state)
        M_IDLE: begin
          if (s) m_state = M_ACK;
          else if (u && !d && m_color < 8) m_color++;
          else if (d && !u && m_color > 3) m_color--;
        end
        M_ACK: begin
          m_state = M_INIT; m_cyc = 0; m_att = 0; pulse = 1'b1;
        end
        M_INIT: begin
          if (dn) m_state = M_PLAY;
          else if (m_cyc == TO - 1) begin
            if (m_att < MR) begin
              m_att++; m_cyc = 0; pulse = 1'b1;
            end else begin
              m_state = M_ERROR;
            end
          end else m_cyc++;
        end
        M_PLAY: begin
          if (ov) m_state = M_IDLE;
          else if (s) m_state = M_ACK;
        end
        default: begin
          if (s) m_state = M_ACK;
        end
      endcase
    end
    e.color     = 4'(m_color);
    e.begin_g   = (m_state == M_PLAY);
    e.init_b    = (m_state == M_INIT);
    e.ack       = (m_state == M_ACK);
    e.init_init = pulse;
    e.ready     = (m_state == M_PLAY);
    e.err       = (m_state == M_ERROR);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check("color", int'(final_COLOR_NUM), int'(got.color));
    check("BEGIN_GAME", int'(BEGIN_GAME), int'(got.begin_g));
    check("INITIALIZE_BOARD", int'(INITIALIZE_BOARD), int'(got.init_b));
    check("ACK_BEGIN_GAME", int'(ACK_BEGIN_GAME), int'(got.ack));
    check("INIT_INIT", int'(INIT_INIT), int'(got.init_init));
    check("BOARD_READY", int'(BOARD_READY), int'(got.ready));
    check("init_error", int'(init_error), int'(got.err));
    rst = 0; btn_start = 0; btn_up = 0; btn_down = 0; init_done = 0; game_over = 0;
  endtask

  task automatic idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; btn_start = 0; btn_up = 0; btn_down = 0; init_done = 0; game_over = 0;

    // Reset with start also asserted: reset must win.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset_color", int'(final_COLOR_NUM), 6);
    check("reset_ack", int'(ACK_BEGIN_GAME), 0);

    // Colour selection with saturation at both ends.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); check("up1", int'(final_COLOR_NUM), 7);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); check("up2", int'(final_COLOR_NUM), 8);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); check("up3_sat", int'(final_COLOR_NUM), 8);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("down_sat", int'(final_COLOR_NUM), 3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0); check("up_down_same", int'(final_COLOR_NUM), 3);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); check("up_from_min", int'(final_COLOR_NUM), 4);

    // Start with btn_up in the same cycle: start wins, colour holds.
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("start_ack", int'(ACK_BEGIN_GAME), 1);
    check("start_color_hold", int'(final_COLOR_NUM), 4);
    idle_cycle();
    check("init_kick", int'(INIT_INIT), 1);
    check("init_level", int'(INITIALIZE_BOARD), 1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("play_begin", int'(BEGIN_GAME), 1);
    check("play_ready", int'(BOARD_READY), 1);
    check("play_init_low", int'(INITIALIZE_BOARD), 0);

    // PLAY: game_over and start together go to IDLE.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("over_start_idle", int'(BEGIN_GAME), 0);
    check("over_start_noack", int'(ACK_BEGIN_GAME), 0);

    // Back into PLAY, then new game from PLAY keeps colour.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("play_restart_ack", int'(ACK_BEGIN_GAME), 1);
    check("play_restart_color", int'(final_COLOR_NUM), 4);

    // Timeout/retry exhaustion; run twice so the second pass proves retries cleared.
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i <= 3 * TO; i++) begin
        idle_cycle();
        check("retry_kick", int'(INIT_INIT), (i == 0 || i == TO || i == 2 * TO) ? 1 : 0);
        check("retry_err", int'(init_error), (i == 3 * TO) ? 1 : 0);
      end
      // Inputs other than start are ignored in ERROR.
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      check("err_hold", int'(init_error), 1);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      check("err_restart", int'(ACK_BEGIN_GAME), 1);
    end

    // init_done on the timeout cycle wins.
    for (int i = 0; i < TO; i++) idle_cycle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("coinc_play", int'(BEGIN_GAME), 1);
    check("coinc_nokick", int'(INIT_INIT), 0);
    check("coinc_noerr", int'(init_error), 0);

    // Reset mid-attempt with btn_up and init_done pending.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    idle_cycle();
    idle_cycle();
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("rst_mid_color", int'(final_COLOR_NUM), 6);
    check("rst_mid_init", int'(INITIALIZE_BOARD), 0);
    check("rst_mid_play", int'(BEGIN_GAME), 0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(63) == 0), 1'($urandom_range(15) == 0),
           1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0),
           1'($urandom_range(9) == 0), 1'($urandom_range(11) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/game_init_ctrl.md
GAME_INIT_CTRL -- requirements
Module: game_init_ctrl

Interface
REQ-001 Parameter INIT_TIMEOUT, default 1024: cycles allowed in INIT per attempt before a retry.
REQ-002 Parameter MAX_RETRY, default 3: retries allowed after the first attempt before ERROR.
REQ-003 clk  input  1  system clock; the only clock; all logic on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 btn_start  input  1  debounced one-cycle start pulse.
REQ-006 btn_up  input  1  debounced one-cycle pulse; raise color count.
REQ-007 btn_down  input  1  debounced one-cycle pulse; lower color count.
REQ-008 init_done  input  1  one-cycle pulse from the board generator; board filled.
REQ-009 game_over  input  1  one-cycle pulse from game logic; board flooded or moves exhausted.
REQ-010 final_COLOR_NUM  output  4  selected color count, range 3..8.
REQ-011 BEGIN_GAME  output  1  level; high in PLAY.
REQ-012 INITIALIZE_BOARD  output  1  level; high in INIT.
REQ-013 ACK_BEGIN_GAME  output  1  one-cycle pulse; start accepted.
REQ-014 INIT_INIT  output  1  one-cycle pulse; kick the board generator.
REQ-015 BOARD_READY  output  1  level; high in PLAY.
REQ-016 init_error  output  1  level; high in ERROR.

Function
REQ-017 All outputs SHALL be registered; a state change on edge N SHALL be visible on outputs after edge N.
REQ-018 States SHALL be IDLE, ACK, INIT, PLAY and ERROR; encoding is free.
REQ-019 IDLE: btn_up SHALL increment final_COLOR_NUM, saturating at 8; btn_down SHALL decrement it, saturating at 3; both in the same cycle SHALL cause no change.
REQ-020 final_COLOR_NUM SHALL change only in IDLE; it SHALL hold in all other states.
REQ-021 IDLE + btn_start SHALL go to ACK; start SHALL take priority, and btn_up/btn_down in that same cycle SHALL be ignored.
REQ-022 ACK SHALL last exactly one cycle with ACK_BEGIN_GAME=1, then go to INIT.
REQ-023 On every INIT entry, INIT_INIT SHALL be 1 for the first INIT cycle only; the attempt timer SHALL be 0 and the retry counter SHALL be 0.
REQ-024 INIT + init_done SHALL go to PLAY.
REQ-025 INIT: the attempt timer SHALL increment each cycle; at INIT_TIMEOUT-1 without init_done, if retries < MAX_RETRY, then retries++, timer clears and INIT_INIT pulses again the next cycle; otherwise the next state SHALL be ERROR.
REQ-026 init_done in the same cycle as a timeout SHALL win: go to PLAY, with no retry and no ERROR.
REQ-027 init_done outside INIT SHALL be ignored.
REQ-028 PLAY + game_over SHALL go to IDLE; PLAY + btn_start SHALL go to ACK (new game, same color count); both in the same cycle SHALL go to IDLE.
REQ-029 ERROR + btn_start SHALL go to ACK; all other inputs SHALL be ignored in ERROR.
REQ-030 game_over SHALL be ignored outside PLAY; btn_start SHALL be ignored in ACK and INIT.
REQ-031 Timer width SHALL be clog2(INIT_TIMEOUT); retry counter width SHALL be clog2(MAX_RETRY+1); neither SHALL wrap.

Reset
REQ-032 rst SHALL force IDLE, final_COLOR_NUM=6, all 1-bit outputs 0, and timer and retry counter 0 on the next edge, from any state.
REQ-033 rst SHALL take priority over every input in the same cycle, including during INIT mid-attempt.

Structure
REQ-034 Package flood_pkg SHALL hold the state enum, MIN_COLORS=3, MAX_COLORS=8 and RESET_COLORS=6.
REQ-035 One sub-module, init_timer, SHALL implement the attempt timer and retry counter (inputs: clear, run; outputs: timeout, exhausted); the FSM SHALL be in the top module.

Verification
REQ-036 After reset: 3 btn_up pulses -> final_COLOR_NUM 7, 8, 8; then 6 btn_down pulses -> final_COLOR_NUM ends at 3; btn_up and btn_down together -> no change.
REQ-037 btn_start in IDLE -> ACK_BEGIN_GAME high 1 cycle, next cycle INIT_INIT high 1 cycle and INITIALIZE_BOARD high; init_done 5 cycles later -> BEGIN_GAME=BOARD_READY=1 and INITIALIZE_BOARD=0.
REQ-038 INIT_TIMEOUT=8, MAX_RETRY=2, no init_done -> INIT_INIT pulses at INIT cycles 0, 8 and 16; after 24 cycles -> init_error=1; then btn_start -> ACK, and on re-entry retries=0.
REQ-039 init_done coincident with the timeout cycle -> PLAY, no extra INIT_INIT pulse, init_error=0.
REQ-040 PLAY with game_over and btn_start in the same cycle -> IDLE and all flags 0; separately, PLAY + btn_start -> ACK with final_COLOR_NUM unchanged.
REQ-041 rst asserted in INIT mid-attempt -> next cycle IDLE, final_COLOR_NUM=6, all flags 0; btn_up in the rst cycle -> ignored.
